// File: rtl/uart_ctrl_if.sv
// Bus bundle for uart_ctrl: RX FIFO side, two TX requesters and transmitter handshake.
// The slave modport is the controller view; master is the surrounding system view.
interface uart_ctrl_if #(
    parameter int RX_DEPTH = 4
);
    localparam int CW = $clog2(RX_DEPTH) + 1;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rx_empty;
    logic [CW-1:0] rx_count;
    logic          rx_overrun;
    logic          ovr_clr;

    logic          req0;
    logic          req1;
    logic [7:0]    req0_data;
    logic [7:0]    req1_data;
    logic          gnt0;
    logic          gnt1;

    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;

    modport slave (
        input  rx_byte, rx_valid, rd_en, ovr_clr,
        input  req0, req1, req0_data, req1_data, tx_busy,
        output rd_data, rx_empty, rx_count, rx_overrun,
        output gnt0, gnt1, tx_start, tx_data
    );

    modport master (
        output rx_byte, rx_valid, rd_en, ovr_clr,
        output req0, req1, req0_data, req1_data, tx_busy,
        input  rd_data, rx_empty, rx_count, rx_overrun,
        input  gnt0, gnt1, tx_start, tx_data
    );
endinterface

// File: rtl/uart_ctrl.sv
// UART controller: edge-captured RX FIFO with sticky overrun, round-robin TX arbiter/launcher.
// Define UART_CTRL_ECHO_EN to add a lowest-priority echo requester fed by every captured RX byte.
module uart_ctrl #(
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    uart_ctrl_if.slave bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        SRC_REQ0,
        SRC_REQ1,
        SRC_ECHO
    } tx_src_e;

    // ---------------- RX FIFO ----------------
    logic [7:0]    mem_q [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          rxv_q;
    logic          armed_q;

    logic capture;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic overrun_evt;

    // armed_q masks the first cycle after reset so a level already high is not seen as an edge
    assign capture     = bus.rx_valid & ~rxv_q & armed_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(RX_DEPTH));
    assign pop         = bus.rd_en & ~empty;
    assign push        = capture & (~full | pop);
    assign overrun_evt = capture & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (overrun_evt) begin
            ovr_d = 1'b1;
        end else if (bus.ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            rxv_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            rxv_q    <= bus.rx_valid;
            armed_q  <= 1'b1;
        end
    end

    // On full with a simultaneous pop, wr_ptr equals rd_ptr: the head slot is reused as the new tail.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.rx_byte;
        end
    end

    assign bus.rd_data    = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.rx_empty   = empty;
    assign bus.rx_count   = count_q;
    assign bus.rx_overrun = ovr_q;

    // ---------------- Echo slot ----------------
`ifdef UART_CTRL_ECHO_EN
    logic       echo_vld_q, echo_vld_d;
    logic [7:0] echo_q, echo_d;
    logic       echo_take;

    always_comb begin
        echo_vld_d = echo_vld_q;
        echo_d     = echo_q;
        if (echo_take) begin
            echo_vld_d = 1'b0;
        end
        if (capture) begin
            echo_vld_d = 1'b1;
            echo_d     = bus.rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_vld_q <= 1'b0;
            echo_q     <= '0;
        end else begin
            echo_vld_q <= echo_vld_d;
            echo_q     <= echo_d;
        end
    end
`endif

    // ---------------- TX arbiter / launcher ----------------
    tx_state_e  state_q, state_d;
    tx_src_e    src_q, src_d;
    logic       prio1_q, prio1_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [3:0] tmo_q, tmo_d;
    logic       tx_start;
    logic       gnt0;
    logic       gnt1;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        prio1_d   = prio1_q;
        tx_data_d = tx_data_q;
        tmo_d     = tmo_q;
        tx_start  = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
`ifdef UART_CTRL_ECHO_EN
        echo_take = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (!bus.tx_busy) begin
                    if (bus.req0 && (!bus.req1 || !prio1_q)) begin
                        src_d     = SRC_REQ0;
                        tx_data_d = bus.req0_data;
                        state_d   = LAUNCH;
                    end else if (bus.req1) begin
                        src_d     = SRC_REQ1;
                        tx_data_d = bus.req1_data;
                        state_d   = LAUNCH;
                    end
`ifdef UART_CTRL_ECHO_EN
                    else if (echo_vld_q) begin
                        src_d     = SRC_ECHO;
                        tx_data_d = echo_q;
                        echo_take = 1'b1;
                        state_d   = LAUNCH;
                    end
`endif
                end
            end
            LAUNCH: begin
                tx_start = 1'b1;
                gnt0     = (src_q == SRC_REQ0);
                gnt1     = (src_q == SRC_REQ1);
                if (src_q == SRC_REQ0) begin
                    prio1_d = 1'b1;
                end else if (src_q == SRC_REQ1) begin
                    prio1_d = 1'b0;
                end
                tmo_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == 4'd14) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            src_q     <= SRC_REQ0;
            prio1_q   <= 1'b0;
            tx_data_q <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            prio1_q   <= prio1_d;
            tx_data_q <= tx_data_d;
            tmo_q     <= tmo_d;
        end
    end

    assign bus.tx_start = tx_start;
    assign bus.tx_data  = tx_data_q;
    assign bus.gnt0     = gnt0;
    assign bus.gnt1     = gnt1;
endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: scoreboard queues for RX bytes and TX launches.
`timescale 1ns/1ps
module tb_uart_ctrl;
    localparam int RX_DEPTH = 4;
    localparam int CW = $clog2(RX_DEPTH) + 1;

    typedef struct {
        logic       g0;
        logic       g1;
        logic [7:0] data;
    } tx_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] rx_exp_q[$];
    tx_exp_t    tx_exp_q[$];
    logic       exp_ovr;

    bit busy_en;
    int busy_len;
    int busy_left;

    uart_ctrl_if #(.RX_DEPTH(RX_DEPTH)) bus ();
    uart_ctrl #(.RX_DEPTH(RX_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // transmitter model: busy for busy_len cycles after each tx_start
    initial begin
        bus.tx_busy = 1'b0;
        busy_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) busy_left = 0;
            else if (busy_en && bus.tx_start && busy_left == 0) busy_left = busy_len;
            if (busy_left > 0) begin
                bus.tx_busy = 1'b1;
                busy_left--;
            end else begin
                bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        bus.rx_byte = b;
        bus.rx_valid = 1'b1;
        if (rx_exp_q.size() < RX_DEPTH) rx_exp_q.push_back(b);
        else exp_ovr = 1'b1;
        repeat (hold) @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b1;
        bus.rx_byte = 8'h99;
        @(negedge clk);
        checks++;
        if (bus.rx_empty !== 1'b1 || bus.rx_count !== '0 || bus.rx_overrun !== 1'b0 || bus.rd_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rx: empty=%b count=%0d ovr=%b rd_data=%h expected 1 0 0 00",
                     bus.rx_empty, bus.rx_count, bus.rx_overrun, bus.rd_data);
        end
        checks++;
        if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_tx: gnt0=%b gnt1=%b tx_start=%b tx_data=%h expected 0 0 0 00",
                     bus.gnt0, bus.gnt1, bus.tx_start, bus.tx_data);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rx_count !== '0 || bus.rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_level: count=%0d empty=%b expected 0 1", bus.rx_count, bus.rx_empty);
        end
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rx_level();
        logic [7:0] exp;
        send_byte(8'hAB, 5000);
        send_byte(8'hFF, 3);
        send_byte(8'h00, 3);
        send_byte(8'h12, 3);
        @(negedge clk);
        checks++;
        if (bus.rx_count !== CW'(4) || bus.rx_empty !== 1'b0 || bus.rx_overrun !== 1'b0) begin
            failures++;
            $display("FAIL rx_level_count: count=%0d empty=%b ovr=%b expected 4 0 0",
                     bus.rx_count, bus.rx_empty, bus.rx_overrun);
        end
        while (rx_exp_q.size() > 0) begin
            @(negedge clk);
            exp = rx_exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp) begin
                failures++;
                $display("FAIL rx_level_pop: rd_data=%h expected %h", bus.rd_data, exp);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        checks++;
        if (bus.rx_count !== '0 || bus.rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL rx_level_drained: count=%0d empty=%b expected 0 1", bus.rx_count, bus.rx_empty);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        exp_ovr = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 2);
        @(negedge clk);
        checks++;
        if (bus.rx_overrun !== exp_ovr || bus.rx_count !== CW'(RX_DEPTH)) begin
            failures++;
            $display("FAIL overrun_set: ovr=%b count=%0d expected %b %0d", bus.rx_overrun, bus.rx_count, exp_ovr, RX_DEPTH);
        end
        while (rx_exp_q.size() > 0) begin
            @(negedge clk);
            exp = rx_exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp) begin
                failures++;
                $display("FAIL overrun_pop: rd_data=%h expected %h", bus.rd_data, exp);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        checks++;
        if (bus.rx_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: ovr=%b expected 1", bus.rx_overrun);
        end
        // pop on empty is ignored
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rx_count !== '0 || bus.rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL empty_pop: count=%0d empty=%b expected 0 1", bus.rx_count, bus.rx_empty);
        end
        bus.rd_en = 1'b0;
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        checks++;
        if (bus.rx_overrun !== 1'b0) begin
            failures++;
            $display("FAIL overrun_clear: ovr=%b expected 0", bus.rx_overrun);
        end
        // overrun event in the same cycle as ovr_clr wins
        for (int i = 0; i < RX_DEPTH; i++) send_byte(8'h21 + 8'(i), 2);
        @(negedge clk);
        bus.rx_byte = 8'h25;
        bus.rx_valid = 1'b1;
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.ovr_clr = 1'b0;
        checks++;
        if (bus.rx_overrun !== 1'b1 || bus.rx_count !== CW'(RX_DEPTH)) begin
            failures++;
            $display("FAIL overrun_vs_clear: ovr=%b count=%0d expected 1 %0d", bus.rx_overrun, bus.rx_count, RX_DEPTH);
        end
        while (rx_exp_q.size() > 0) begin
            @(negedge clk);
            exp = rx_exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp) begin
                failures++;
                $display("FAIL overrun2_pop: rd_data=%h expected %h", bus.rd_data, exp);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        bus.ovr_clr = 1'b1;
        @(negedge clk);
        bus.ovr_clr = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < RX_DEPTH; i++) send_byte(8'h10 + 8'(i), 2);
        @(negedge clk);
        exp = rx_exp_q.pop_front();
        checks++;
        if (bus.rd_data !== exp) begin
            failures++;
            $display("FAIL full_pp_head: rd_data=%h expected %h", bus.rd_data, exp);
        end
        bus.rd_en = 1'b1;
        bus.rx_byte = 8'h14;
        bus.rx_valid = 1'b1;
        rx_exp_q.push_back(8'h14);
        @(negedge clk);
        bus.rd_en = 1'b0;
        bus.rx_valid = 1'b0;
        checks++;
        if (bus.rx_count !== CW'(RX_DEPTH) || bus.rx_overrun !== 1'b0) begin
            failures++;
            $display("FAIL full_pp_count: count=%0d ovr=%b expected %0d 0", bus.rx_count, bus.rx_overrun, RX_DEPTH);
        end
        while (rx_exp_q.size() > 0) begin
            @(negedge clk);
            exp = rx_exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp) begin
                failures++;
                $display("FAIL full_pp_pop: rd_data=%h expected %h", bus.rd_data, exp);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
    endtask

    task automatic test_tx_arb();
        tx_exp_t    e;
        int         launches = 0;
        bit         just = 1'b0;
        logic [7:0] last_data = 8'h00;
        repeat (40) @(negedge clk);
        busy_en = 1'b1;
        busy_len = 10;
        tx_exp_q.push_back('{1'b1, 1'b0, 8'h41});
        tx_exp_q.push_back('{1'b0, 1'b1, 8'h42});
        tx_exp_q.push_back('{1'b1, 1'b0, 8'h41});
        bus.req0_data = 8'h41;
        bus.req1_data = 8'h42;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        for (int cyc = 1; cyc <= 300 && launches < 3; cyc++) begin
            @(negedge clk);
            if (just) begin
                just = 1'b0;
                checks++;
                if (bus.tx_start !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.tx_data !== last_data) begin
                    failures++;
                    $display("FAIL arb_pulse_width: tx_start=%b gnt0=%b gnt1=%b tx_data=%h expected 0 0 0 %h",
                             bus.tx_start, bus.gnt0, bus.gnt1, bus.tx_data, last_data);
                end
            end
            if (bus.tx_start === 1'b1) begin
                if (launches == 0) begin
                    checks++;
                    if (cyc != 1) begin
                        failures++;
                        $display("FAIL arb_latency: first launch at cycle %0d expected 1", cyc);
                    end
                end
                e = tx_exp_q.pop_front();
                checks++;
                if (bus.gnt0 !== e.g0 || bus.gnt1 !== e.g1 || bus.tx_data !== e.data) begin
                    failures++;
                    $display("FAIL arb_grant%0d: gnt0=%b gnt1=%b tx_data=%h expected %b %b %h",
                             launches, bus.gnt0, bus.gnt1, bus.tx_data, e.g0, e.g1, e.data);
                end
                last_data = e.data;
                just = 1'b1;
                launches++;
                if (launches == 3) begin
                    bus.req0 = 1'b0;
                    bus.req1 = 1'b0;
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (launches != 3) begin
            failures++;
            $display("FAIL arb_launch_count: launches=%0d expected 3", launches);
        end
        tx_exp_q.delete();
        repeat (30) @(negedge clk);
        busy_en = 1'b0;
    endtask

    task automatic test_tx_timeout();
        tx_exp_t e;
        int      t1 = -1;
        int      t2 = -1;
        busy_en = 1'b0;
        tx_exp_q.push_back('{1'b0, 1'b1, 8'h5A});
        tx_exp_q.push_back('{1'b0, 1'b1, 8'h5A});
        bus.req1_data = 8'h5A;
        bus.req1 = 1'b1;
        for (int cyc = 1; cyc <= 100 && t2 < 0; cyc++) begin
            @(negedge clk);
            if (t1 >= 0 && cyc == t1 + 1) begin
                checks++;
                if (bus.tx_start !== 1'b0) begin
                    failures++;
                    $display("FAIL timeout_single_start: tx_start=%b expected 0", bus.tx_start);
                end
            end
            if (bus.tx_start === 1'b1) begin
                e = tx_exp_q.pop_front();
                checks++;
                if (bus.gnt0 !== e.g0 || bus.gnt1 !== e.g1 || bus.tx_data !== e.data) begin
                    failures++;
                    $display("FAIL timeout_grant: gnt0=%b gnt1=%b tx_data=%h expected %b %b %h",
                             bus.gnt0, bus.gnt1, bus.tx_data, e.g0, e.g1, e.data);
                end
                if (t1 < 0) t1 = cyc;
                else t2 = cyc;
            end
        end
        bus.req1 = 1'b0;
        checks++;
        if (t1 < 0 || t2 < 0 || (t2 - t1) != 17) begin
            failures++;
            $display("FAIL timeout_relaunch: launch gap=%0d expected 17 (t1=%0d t2=%0d)", t2 - t1, t1, t2);
        end
        tx_exp_q.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic test_echo();
        logic [7:0] exp;
        int         starts = 0;
        bit         seen = 1'b0;
        busy_en = 1'b0;
`ifdef UART_CTRL_ECHO_EN
        tx_exp_q.push_back('{1'b0, 1'b0, 8'h55});
        send_byte(8'h55, 2);
        for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                tx_exp_t e;
                e = tx_exp_q.pop_front();
                seen = 1'b1;
                checks++;
                if (bus.tx_data !== e.data || bus.gnt0 !== e.g0 || bus.gnt1 !== e.g1) begin
                    failures++;
                    $display("FAIL echo_launch: tx_data=%h gnt0=%b gnt1=%b expected %h %b %b",
                             bus.tx_data, bus.gnt0, bus.gnt1, e.data, e.g0, e.g1);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL echo_timeout: no tx_start within 30 cycles expected 1 launch");
        end
        tx_exp_q.delete();
`else
        send_byte(8'h66, 2);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) starts++;
        end
        checks++;
        if (starts != 0) begin
            failures++;
            $display("FAIL no_echo: tx_start count=%0d expected 0", starts);
        end
`endif
        while (rx_exp_q.size() > 0) begin
            @(negedge clk);
            exp = rx_exp_q.pop_front();
            checks++;
            if (bus.rd_data !== exp) begin
                failures++;
                $display("FAIL echo_rx_pop: rd_data=%h expected %h", bus.rd_data, exp);
            end
            bus.rd_en = 1'b1;
            @(negedge clk);
            bus.rd_en = 1'b0;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_tx();
        bit seen = 1'b0;
        busy_en = 1'b1;
        busy_len = 60;
        @(negedge clk);
        bus.req0_data = 8'h33;
        bus.req0 = 1'b1;
        bus.rx_byte = 8'h77;
        bus.rx_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) seen = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.rx_valid = 1'b0;
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midtx_launch: no tx_start within 40 cycles expected 1 launch");
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rx_count !== CW'(1) || bus.tx_data !== 8'h33) begin
            failures++;
            $display("FAIL midtx_pre_reset: count=%0d tx_data=%h expected 1 33", bus.rx_count, bus.tx_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.tx_start !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0 || bus.tx_data !== 8'h00 ||
            bus.rx_count !== '0 || bus.rx_empty !== 1'b1 || bus.rx_overrun !== 1'b0 || bus.rd_data !== 8'h00) begin
            failures++;
            $display("FAIL midtx_async_reset: tx_start=%b gnt0=%b gnt1=%b tx_data=%h count=%0d empty=%b ovr=%b rd_data=%h expected 0 0 0 00 0 1 0 00",
                     bus.tx_start, bus.gnt0, bus.gnt1, bus.tx_data, bus.rx_count, bus.rx_empty, bus.rx_overrun, bus.rd_data);
        end
        rx_exp_q.delete();
        @(negedge clk);
        bus.req0_data = 8'h34;
        bus.req0 = 1'b1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 2 && !seen; cyc++) begin
            @(negedge clk);
            if (bus.gnt0 === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (bus.tx_data !== 8'h34 || bus.gnt1 !== 1'b0) begin
                    failures++;
                    $display("FAIL midtx_regrant_data: tx_data=%h gnt1=%b expected 34 0", bus.tx_data, bus.gnt1);
                end
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL midtx_regrant: gnt0 not seen within 2 cycles after release");
        end
        bus.req0 = 1'b0;
        busy_en = 1'b0;
        repeat (80) @(negedge clk);
    endtask

    initial begin
        exp_ovr = 1'b0;
        busy_en = 1'b0;
        busy_len = 10;
        bus.rx_byte = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rd_en = 1'b0;
        bus.ovr_clr = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.req0_data = 8'h00;
        bus.req1_data = 8'h00;
        test_reset();
        test_rx_level();
        test_overrun();
        test_full_push_pop();
        test_tx_arb();
        test_tx_timeout();
        test_echo();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 The module SHALL have parameter RX_DEPTH, default 4, meaning RX FIFO depth in bytes (power of 2, 2..16).
REQ-002 The module SHALL have port clk, input, 1 bit: single system clock, 100 MHz nominal.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The module SHALL have port rx_byte, input, 8 bits: received byte from UART receiver.
REQ-005 The module SHALL have port rx_valid, input, 1 bit: UART byte-ready level, held high for one or more cycles per byte.
REQ-006 The module SHALL have port rd_en, input, 1 bit: pop one byte from the RX FIFO.
REQ-007 The module SHALL have port rd_data, output, 8 bits: RX FIFO head byte.
REQ-008 The module SHALL have ports rx_empty, output, 1 bit, and rx_count, output, clog2(RX_DEPTH)+1 bits: FIFO empty flag and occupancy.
REQ-009 The module SHALL have port rx_overrun, output, 1 bit, and ovr_clr, input, 1 bit: sticky overrun flag and its clear.
REQ-010 The module SHALL have ports req0 and req1, input, 1 bit each, with req0_data and req1_data, input, 8 bits each: TX requesters 0 (CPU) and 1 (debug).
REQ-011 The module SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle grant pulses.
REQ-012 The module SHALL have ports tx_start, output, 1 bit, and tx_data, output, 8 bits: transmitter launch pulse and byte.
REQ-013 The module SHALL have port tx_busy, input, 1 bit: transmitter busy.

Function
REQ-014 RX capture SHALL occur on the rising edge of rx_valid only: one FIFO write per byte, regardless of how long rx_valid stays high.
REQ-015 A write to a full FIFO SHALL drop the byte, set rx_overrun, and leave FIFO contents unchanged.
REQ-016 rd_en on an empty FIFO SHALL be ignored.
REQ-017 rd_data SHALL always present the head byte; a pop SHALL advance it on the next cycle.
REQ-018 A simultaneous capture and pop SHALL leave rx_count unchanged, including when the FIFO is full; in the full case the write is accepted.
REQ-019 Pointers SHALL wrap modulo RX_DEPTH.
REQ-020 ovr_clr SHALL clear rx_overrun; an overrun event in the same cycle SHALL win.
REQ-021 The TX FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
- IDLE -> LAUNCH: any request active and tx_busy=0; winner latched.
- LAUNCH: tx_start=1 and gntN=1 for exactly one cycle; tx_data=winner data; then -> WAIT_BUSY.
- WAIT_BUSY -> WAIT_DONE when tx_busy=1; -> IDLE after 15 cycles without tx_busy (timeout).
- WAIT_DONE -> IDLE when tx_busy=0.
REQ-022 Arbitration SHALL be round-robin: when both requesters are active, the one not granted last wins; after reset, req0 has priority.
REQ-023 Requesters SHALL hold reqN and reqN_data until gntN; the controller samples data only in the IDLE->LAUNCH cycle.
REQ-024 tx_data SHALL hold its value from LAUNCH until the next LAUNCH.
REQ-025 Launch latency SHALL be 1 cycle from request sampled in IDLE to tx_start.

Reset
REQ-026 While rst_n=0, the following SHALL hold asynchronously:
- FIFO emptied; rx_empty=1, rx_count=0, rx_overrun=0, rd_data=0.
- gnt0=gnt1=0, tx_start=0, tx_data=0.
- FSM=IDLE; round-robin pointer selects req0; rx_valid edge register=0.
REQ-027 Reset asserted mid-transmission SHALL abandon the transaction; no grant is reissued after release.
REQ-028 An rx_valid already high at reset release SHALL NOT capture a byte.

Configuration
REQ-029 With UART_CTRL_ECHO_EN defined, each captured RX byte (including dropped ones) SHALL be latched into a one-entry echo slot and transmitted as a third requester at lowest priority, outside the round-robin.
- A new byte arriving while the slot is occupied SHALL overwrite it.
- An echo launch SHALL pulse no gnt.
REQ-030 Without UART_CTRL_ECHO_EN, no echo logic SHALL exist and TX SHALL serve only req0 and req1.

Verification
REQ-031 rx_valid high 5000 cycles with 0xAB, then 0xFF, 0x00, 0x12 -> rx_count=4 and pops return AB, FF, 00, 12.
REQ-032 Five bytes 0x01..0x05 with no pops, RX_DEPTH=4 -> rx_overrun=1 and pops return 01..04; ovr_clr -> rx_overrun=0.
REQ-033 req0=req1=1 (data 0x41, 0x42) held, tx_busy model 10 cycles -> grants alternate gnt0, gnt1, gnt0; tx_data 41, 42, 41.
REQ-034 req1 only with tx_busy stuck 0 -> tx_start once, FSM back to IDLE after 15-cycle timeout, then next launch.
REQ-035 rst_n pulled low during WAIT_DONE -> all outputs zero immediately; after release with req0=1 -> gnt0 within 2 cycles.
REQ-036 With UART_CTRL_ECHO_EN, RX 0x55 while idle and no requests -> tx_start with tx_data=0x55 and gnt0=gnt1=0.
